// File: rtl/logo_mover.sv
// logo_mover: per-frame motion controller for a sprite.
// On each enabled start-of-frame it runs VEL -> MOVE -> WALL -> PUBLISH and
// publishes a new integer top-left position four cycles after the pulse.
// Position/velocity are signed fixed-point with FRAC fractional bits.
// Ports:
//   clk, reset (sync, active-high)
//   startOfFrame - one-cycle frame pulse (ignored while busy)
//   enable       - 0 skips frames, outputs hold, requests stay pending
//   collision    - reverses vertical velocity at the next VEL
//   speed_up     - grows both velocity magnitudes by V_STEP (sat V_MAX)
//   topLeft_x/y  - published integer pixel position
//   bounce       - one-cycle pulse when a wall clamp happened this frame
//   busy         - FSM not in IDLE
module logo_mover #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int OBJ_W    = 128,
  parameter int OBJ_H    = 64,
  parameter int FRAC     = 4,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 100,
  parameter int INIT_VX  = 32,
  parameter int INIT_VY  = 16,
  parameter int V_STEP   = 8,
  parameter int V_MAX    = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        collision,
  input  logic        speed_up,
  output logic [31:0] topLeft_x,
  output logic [31:0] topLeft_y,
  output logic        bounce,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, VEL, MOVE, WALL, PUBLISH} state_e;

  localparam logic signed [31:0] XMAX   = 32'(SCREEN_W - OBJ_W) <<< FRAC;
  localparam logic signed [31:0] YMAX   = 32'(SCREEN_H - OBJ_H) <<< FRAC;
  localparam logic signed [31:0] RST_PX = 32'(INIT_X) <<< FRAC;
  localparam logic signed [31:0] RST_PY = 32'(INIT_Y) <<< FRAC;
  localparam logic signed [31:0] VSTEP  = 32'(V_STEP);
  localparam logic signed [31:0] VMAX   = 32'(V_MAX);

  state_e state_q, state_d;
  logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [31:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [31:0] tl_x_q, tl_x_d, tl_y_q, tl_y_d;
  logic col_pend_q, col_pend_d, spd_pend_q, spd_pend_d;
  logic col_late_q, col_late_d, spd_late_q, spd_late_d;
  logic hit_q, hit_d, bounce_q, bounce_d;
  logic signed [31:0] vy_neg;

  function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

  // Magnitude + V_STEP saturating at V_MAX, sign kept, zero stays zero.
  function automatic logic signed [31:0] speed(input logic signed [31:0] v);
    logic signed [31:0] m;
    m = abs32(v);
    if (m == 0) return '0;
    m = m + VSTEP;
    if (m > VMAX) m = VMAX;
    return (v < 0) ? -m : m;
  endfunction

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    vel_x_d    = vel_x_q;
    vel_y_d    = vel_y_q;
    tl_x_d     = tl_x_q;
    tl_y_d     = tl_y_q;
    hit_d      = hit_q;
    bounce_d   = 1'b0;
    col_pend_d = col_pend_q | collision;
    spd_pend_d = spd_pend_q | speed_up;
    col_late_d = col_late_q;
    spd_late_d = spd_late_q;
    vy_neg     = col_pend_q ? -vel_y_q : vel_y_q;

    // Requests landing from VEL onward missed this frame's velocity update;
    // remember them separately so the PUBLISH clear does not drop them.
    if (state_q == VEL || state_q == MOVE || state_q == WALL) begin
      col_late_d = col_late_q | collision;
      spd_late_d = spd_late_q | speed_up;
    end

    case (state_q)
      IDLE: if (startOfFrame && enable) begin
        state_d = VEL;
        hit_d   = 1'b0;
      end
      VEL: begin
        vel_y_d = spd_pend_q ? speed(vy_neg) : vy_neg;
        vel_x_d = spd_pend_q ? speed(vel_x_q) : vel_x_q;
        state_d = MOVE;
      end
      MOVE: begin
        pos_x_d = pos_x_q + vel_x_q;
        pos_y_d = pos_y_q + vel_y_q;
        state_d = WALL;
      end
      WALL: begin
        if (pos_x_q < 0) begin
          pos_x_d = '0;   vel_x_d = abs32(vel_x_q);  hit_d = 1'b1;
        end else if (pos_x_q > XMAX) begin
          pos_x_d = XMAX; vel_x_d = -abs32(vel_x_q); hit_d = 1'b1;
        end
        if (pos_y_q < 0) begin
          pos_y_d = '0;   vel_y_d = abs32(vel_y_q);  hit_d = 1'b1;
        end else if (pos_y_q > YMAX) begin
          pos_y_d = YMAX; vel_y_d = -abs32(vel_y_q); hit_d = 1'b1;
        end
        state_d = PUBLISH;
      end
      PUBLISH: begin
        tl_x_d     = pos_x_q >>> FRAC;
        tl_y_d     = pos_y_q >>> FRAC;
        bounce_d   = hit_q;
        col_pend_d = collision | col_late_q;
        spd_pend_d = speed_up | spd_late_q;
        col_late_d = 1'b0;
        spd_late_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_x_q    <= RST_PX;
      pos_y_q    <= RST_PY;
      vel_x_q    <= 32'(INIT_VX);
      vel_y_q    <= 32'(INIT_VY);
      tl_x_q     <= 32'(INIT_X);
      tl_y_q     <= 32'(INIT_Y);
      col_pend_q <= 1'b0;
      spd_pend_q <= 1'b0;
      col_late_q <= 1'b0;
      spd_late_q <= 1'b0;
      hit_q      <= 1'b0;
      bounce_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      vel_x_q    <= vel_x_d;
      vel_y_q    <= vel_y_d;
      tl_x_q     <= tl_x_d;
      tl_y_q     <= tl_y_d;
      col_pend_q <= col_pend_d;
      spd_pend_q <= spd_pend_d;
      col_late_q <= col_late_d;
      spd_late_q <= spd_late_d;
      hit_q      <= hit_d;
      bounce_q   <= bounce_d;
    end
  end

  assign topLeft_x = tl_x_q;
  assign topLeft_y = tl_y_q;
  assign bounce    = bounce_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logo_mover.sv
// Directed bench for logo_mover: three instances (defaults, right-wall start,
// top-wall start) share one stimulus stream; expected values are hand-computed.
module tb_logo_mover;
  logic clk = 1'b0, reset = 1'b1, sof = 1'b0, en = 1'b1, col = 1'b0, spd = 1'b0;
  logic [31:0] dx, dy, rx, ry, tx, ty;
  logic db, dbusy, rb, rbusy, tb, tbusy;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  logo_mover u_dut (.clk(clk), .reset(reset), .startOfFrame(sof), .enable(en),
    .collision(col), .speed_up(spd), .topLeft_x(dx), .topLeft_y(dy),
    .bounce(db), .busy(dbusy));
  logo_mover #(.INIT_X(510), .INIT_VX(32)) u_rw (.clk(clk), .reset(reset),
    .startOfFrame(sof), .enable(en), .collision(col), .speed_up(spd),
    .topLeft_x(rx), .topLeft_y(ry), .bounce(rb), .busy(rbusy));
  logo_mover #(.INIT_Y(0), .INIT_VY(-16)) u_tw (.clk(clk), .reset(reset),
    .startOfFrame(sof), .enable(en), .collision(col), .speed_up(spd),
    .topLeft_x(tx), .topLeft_y(ty), .bounce(tb), .busy(tbusy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Pulse startOfFrame at E0, return #1 after E4 (new position visible).
  task automatic frame();
    @(negedge clk) sof = 1'b1;
    @(posedge clk);
    #1 sof = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_x", dx, 100);
    chk("rst_y", dy, 100);
    chk("rst_bounce", {31'b0, db}, 0);
    chk("rst_busy", {31'b0, dbusy}, 0);
    chk("rst_rw_x", rx, 510);
    chk("rst_tw_y", ty, 0);

    // frame 1, with busy checked just after E0
    @(negedge clk) sof = 1'b1;
    @(posedge clk);
    #1 sof = 1'b0;
    chk("busy_after_e0", {31'b0, dbusy}, 1);
    repeat (3) @(posedge clk);
    #1 chk("busy_before_e4", {31'b0, dbusy}, 1);
    @(posedge clk);
    #1;
    chk("f1_x", dx, 102);
    chk("f1_y", dy, 101);
    chk("f1_bounce", {31'b0, db}, 0);
    chk("f1_busy", {31'b0, dbusy}, 0);
    chk("rw_f1_x", rx, 512);
    chk("rw_f1_bounce", {31'b0, rb}, 0);
    chk("tw_f1_y", ty, 0);
    chk("tw_f1_bounce", {31'b0, tb}, 1);
    @(posedge clk);
    #1 chk("tw_bounce_one_cycle", {31'b0, tb}, 0);

    frame();
    chk("rw_f2_x", rx, 512);
    chk("rw_f2_bounce", {31'b0, rb}, 1);
    chk("tw_f2_y", ty, 1);
    chk("tw_f2_bounce", {31'b0, tb}, 0);
    @(posedge clk);
    #1 chk("rw_bounce_one_cycle", {31'b0, rb}, 0);
    frame();
    chk("rw_f3_x", rx, 510);
    frame();
    chk("f4_x", dx, 108);
    chk("f4_y", dy, 104);
    chk("f4_bounce", {31'b0, db}, 0);

    // collision + speed-up in the same idle cycle
    do_reset();
    @(negedge clk) begin col = 1'b1; spd = 1'b1; end
    @(negedge clk) begin col = 1'b0; spd = 1'b0; end
    frame();
    chk("cs_x", dx, 102);
    chk("cs_y", dy, 98);

    // collision arriving during MOVE applies to the following frame
    do_reset();
    @(negedge clk) sof = 1'b1;
    @(posedge clk);
    #1 sof = 1'b0;
    @(posedge clk);
    #1 col = 1'b1;
    @(posedge clk);
    #1 col = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("late_f1_y", dy, 101);
    frame();
    chk("late_f2_y", dy, 100);
    chk("late_f2_x", dx, 104);

    // pause: three frames with enable low
    do_reset();
    en = 1'b0;
    repeat (3) frame();
    chk("pause_x", dx, 100);
    chk("pause_y", dy, 100);
    chk("pause_busy", {31'b0, dbusy}, 0);
    en = 1'b1;

    // reset sampled at E2 of an enabled frame
    @(negedge clk) sof = 1'b1;
    @(posedge clk);
    #1 sof = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_busy", {31'b0, dbusy}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_x", dx, 100);
    chk("midrst_y", dy, 100);
    chk("midrst_bounce", {31'b0, db}, 0);
    chk("midrst_busy_late", {31'b0, dbusy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
